// File: rtl/wb_retire_queue_pkg.sv
// -----------------------------------------------------------------------------
// wb_retire_queue_pkg
// Shared configuration for the writeback retire queue: default geometry and
// small width helpers used by the queue, its forwarding matcher and the bus
// interface. An entry is packed as {reg[AW-1:0], data[DW-1:0]}.
// -----------------------------------------------------------------------------
package wb_retire_queue_pkg;

    localparam int WB_DEPTH = 4;   // queue entries, power of two, >= 2
    localparam int WB_AW    = 5;   // register index width
    localparam int WB_DW    = 32;  // data width

    // Pointer width for a queue of the given depth.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Count needs one extra bit so that "full" (count == DEPTH) is distinct
    // from "empty" (count == 0) even though the pointers are equal in both.
    function automatic int count_width(input int depth);
        return ptr_width(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_retire_queue_if.sv
// -----------------------------------------------------------------------------
// wb_retire_queue_if
// Bundles every non-clock signal of the retire queue.
//   mem_valid/mem_reg/mem_data   load result in
//   alu_valid/alu_reg/alu_data   ALU result in
//   ready                        queue can take two entries this cycle
//   overflow                     sticky, an enqueue was dropped
//   write1/write_reg1/write_data1  register file write port
//   reg_a1/reg_b1/reg_c1         decode read indices
//   hit_*/fwd_data_*             forwarding result per read index
// Modport slave is the queue side, master is the producer/consumer side.
// -----------------------------------------------------------------------------
interface wb_retire_queue_if
    import wb_retire_queue_pkg::*;
#(
    parameter int AW = WB_AW,
    parameter int DW = WB_DW
) ();

    logic          mem_valid;
    logic [AW-1:0] mem_reg;
    logic [DW-1:0] mem_data;
    logic          alu_valid;
    logic [AW-1:0] alu_reg;
    logic [DW-1:0] alu_data;
    logic          ready;
    logic          overflow;
    logic          write1;
    logic [AW-1:0] write_reg1;
    logic [DW-1:0] write_data1;
    logic [AW-1:0] reg_a1;
    logic [AW-1:0] reg_b1;
    logic [AW-1:0] reg_c1;
    logic          hit_a;
    logic          hit_b;
    logic          hit_c;
    logic [DW-1:0] fwd_data_a;
    logic [DW-1:0] fwd_data_b;
    logic [DW-1:0] fwd_data_c;

    modport slave (
        input  mem_valid, mem_reg, mem_data,
        input  alu_valid, alu_reg, alu_data,
        input  reg_a1, reg_b1, reg_c1,
        output ready, overflow,
        output write1, write_reg1, write_data1,
        output hit_a, hit_b, hit_c,
        output fwd_data_a, fwd_data_b, fwd_data_c
    );

    modport master (
        output mem_valid, mem_reg, mem_data,
        output alu_valid, alu_reg, alu_data,
        output reg_a1, reg_b1, reg_c1,
        input  ready, overflow,
        input  write1, write_reg1, write_data1,
        input  hit_a, hit_b, hit_c,
        input  fwd_data_a, fwd_data_b, fwd_data_c
    );

endinterface

// File: rtl/wb_retire_queue_fwd_match.sv
// -----------------------------------------------------------------------------
// wb_fwd_match
// Forwarding lookup for one decode read index against the retire queue.
// Ports:
//   idx         read index to look up (index 0 never hits)
//   slots       packed slot array, each {reg, data}
//   valid_mask  one bit per slot, set when the slot holds a pending entry
//   head        slot index of the oldest entry
//   hit         idx matches at least one pending entry
//   data        data of the newest matching entry, 0 when no hit
// -----------------------------------------------------------------------------
module wb_fwd_match
    import wb_retire_queue_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW,
    localparam int PW   = ptr_width(DEPTH),
    localparam int EW   = AW + DW
) (
    input  logic [AW-1:0]            idx,
    input  logic [DEPTH-1:0][EW-1:0] slots,
    input  logic [DEPTH-1:0]         valid_mask,
    input  logic [PW-1:0]            head,
    output logic                     hit,
    output logic [DW-1:0]            data
);

    // Walk from oldest to newest; a later match overwrites an earlier one, so
    // the newest matching entry is what remains at the end.
    always_comb begin
        // NOTE: default every output first so no path through the block leaves
        // a value unassigned (which would infer a latch).
        hit  = 1'b0;
        data = '0;
        if (idx != '0) begin
            for (int age = 0; age < DEPTH; age++) begin
                if (valid_mask[head + PW'(age)] &&
                    slots[head + PW'(age)][EW-1:DW] == idx) begin
                    hit  = 1'b1;
                    data = slots[head + PW'(age)][DW-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/wb_retire_queue.sv
// -----------------------------------------------------------------------------
// wb_retire_queue
// Writeback retire queue in front of the single register file write port.
// Takes up to two results per cycle (load result older than ALU result),
// keeps them in program order and retires one per cycle. Pending entries are
// forwarded to three decode read ports.
// Ports:
//   CLK    clock, all state updates on posedge
//   RESET  asynchronous, active-low reset
//   bus    wb_retire_queue_if.slave (results in, write port out, forwarding)
// -----------------------------------------------------------------------------
module wb_retire_queue
    import wb_retire_queue_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic              CLK,
    input  logic              RESET,
    wb_retire_queue_if.slave  bus
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam int EW = AW + DW;

    logic [DEPTH-1:0][EW-1:0] slots;
    logic [PW-1:0]            head;
    logic [PW-1:0]            tail;
    logic [CW-1:0]            count;
    logic                     overflow_q;

    logic                     ready;
    logic                     mem_take;
    logic                     alu_take;
    logic                     drop;
    logic                     deq;
    logic [1:0]               enq_n;
    logic [DEPTH-1:0]         valid_mask;

    // Admission looks only at registered count: room for two means the pair
    // can always be accepted, whether or not the head drains this cycle.
    always_comb begin
        ready    = (count <= CW'(DEPTH - 2));
        mem_take = ready && bus.mem_valid && (bus.mem_reg != '0);
        alu_take = ready && bus.alu_valid && (bus.alu_reg != '0);
        drop     = !ready && (bus.mem_valid || bus.alu_valid);
        deq      = (count != '0);
        enq_n    = {1'b0, mem_take} + {1'b0, alu_take};
    end

    // A slot is occupied when its distance from head (mod DEPTH) is below count.
    always_comb begin
        valid_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_mask[i] = ({1'b0, PW'(PW'(i) - head)} < count);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of block order.
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            head       <= head + PW'(deq);
            tail       <= tail + PW'(enq_n);
            count      <= count + CW'(enq_n) - CW'(deq);
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // NOTE: slot storage is deliberately not reset; an entry is only ever read
    // when count/valid_mask mark it occupied, so stale contents are harmless.
    // The load result takes the older (lower) slot; the ALU result follows it,
    // or takes the tail slot itself when there is no load this cycle.
    always_ff @(posedge CLK) begin
        if (mem_take) begin
            slots[tail] <= {bus.mem_reg, bus.mem_data};
        end
        if (alu_take) begin
            slots[tail + PW'(mem_take)] <= {bus.alu_reg, bus.alu_data};
        end
    end

    // Head entry drives the write port directly; it pops at the next edge.
    always_comb begin
        bus.ready       = ready;
        bus.overflow    = overflow_q;
        bus.write1      = deq;
        bus.write_reg1  = deq ? slots[head][EW-1:DW] : '0;
        bus.write_data1 = deq ? slots[head][DW-1:0]  : '0;
    end

    wb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd_a (
        .idx        (bus.reg_a1),
        .slots      (slots),
        .valid_mask (valid_mask),
        .head       (head),
        .hit        (bus.hit_a),
        .data       (bus.fwd_data_a)
    );

    wb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd_b (
        .idx        (bus.reg_b1),
        .slots      (slots),
        .valid_mask (valid_mask),
        .head       (head),
        .hit        (bus.hit_b),
        .data       (bus.fwd_data_b)
    );

    wb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd_c (
        .idx        (bus.reg_c1),
        .slots      (slots),
        .valid_mask (valid_mask),
        .head       (head),
        .hit        (bus.hit_c),
        .data       (bus.fwd_data_c)
    );

endmodule

// File: tb/tb_wb_retire_queue.sv
// -----------------------------------------------------------------------------
// tb_wb_retire_queue
// Self-checking bench for wb_retire_queue. A program-order queue model tracks
// pending writes; every cycle all outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_wb_retire_queue;
    import wb_retire_queue_pkg::*;

    localparam int DEPTH = WB_DEPTH;
    localparam int AW    = WB_AW;
    localparam int DW    = WB_DW;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    wb_retire_queue_if #(.AW(AW), .DW(DW)) bus ();

    wb_retire_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } ent_t;

    ent_t q[$];      // pending writes, oldest first
    bit   ovf;       // model of sticky overflow
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Newest pending entry for idx; index 0 never matches.
    task automatic lookup(input logic [AW-1:0] idx, output bit hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (idx != '0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].r == idx) begin
                    hit = 1'b1;
                    d   = q[i].d;
                    break;
                end
            end
        end
    endtask

    task automatic check_outputs();
        bit            h;
        logic [DW-1:0] d;
        check("ready", bus.ready, (q.size() <= DEPTH - 2));
        check("overflow", bus.overflow, ovf);
        check("write1", bus.write1, (q.size() > 0));
        check("write_reg1", bus.write_reg1, (q.size() > 0) ? q[0].r : '0);
        check("write_data1", bus.write_data1, (q.size() > 0) ? q[0].d : '0);
        lookup(bus.reg_a1, h, d);
        check("hit_a", bus.hit_a, h);
        check("fwd_data_a", bus.fwd_data_a, d);
        lookup(bus.reg_b1, h, d);
        check("hit_b", bus.hit_b, h);
        check("fwd_data_b", bus.fwd_data_b, d);
        lookup(bus.reg_c1, h, d);
        check("hit_c", bus.hit_c, h);
        check("fwd_data_c", bus.fwd_data_c, d);
    endtask

    // One clock: drive at negedge, check, then apply the queue rules at posedge.
    task automatic step(input bit mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                        input bit av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                        input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic [AW-1:0] rc);
        bit rdy;
        @(negedge CLK);
        bus.mem_valid = mv;  bus.mem_reg = mr;  bus.mem_data = md;
        bus.alu_valid = av;  bus.alu_reg = ar;  bus.alu_data = ad;
        bus.reg_a1 = ra;     bus.reg_b1 = rb;   bus.reg_c1 = rc;
        #1;
        check_outputs();
        @(posedge CLK);
        rdy = (q.size() <= DEPTH - 2);
        if (q.size() > 0) void'(q.pop_front());
        if (rdy) begin
            if (mv && mr != '0) q.push_back('{r: mr, d: md});
            if (av && ar != '0) q.push_back('{r: ar, d: ad});
        end else if (mv || av) begin
            ovf = 1'b1;
        end
    endtask

    task automatic idle(input logic [AW-1:0] ra);
        step(1'b0, '0, '0, 1'b0, '0, '0, ra, '0, '0);
    endtask

    // Assert reset between edges and check the empty-queue outputs at once.
    task automatic do_reset(input logic [AW-1:0] ra);
        @(negedge CLK);
        bus.mem_valid = 1'b0;
        bus.alu_valid = 1'b0;
        bus.reg_a1    = ra;
        RESET         = 1'b0;
        #1;
        check("rst_write1", bus.write1, 1'b0);
        check("rst_write_reg1", bus.write_reg1, '0);
        check("rst_write_data1", bus.write_data1, '0);
        check("rst_ready", bus.ready, 1'b1);
        check("rst_overflow", bus.overflow, 1'b0);
        check("rst_hit_a", bus.hit_a, 1'b0);
        check("rst_fwd_data_a", bus.fwd_data_a, '0);
        q.delete();
        ovf = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    initial begin
        bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;
        bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
        bus.reg_a1 = '0; bus.reg_b1 = '0; bus.reg_c1 = '0;
        ovf = 1'b0;

        do_reset(5'd3);

        // Dual enqueue to the same register: load first, then ALU; forward newest.
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd3, 5'd0, 5'd0);
        step(1'b0, '0, '0, 1'b0, '0, '0, 5'd3, 5'd3, 5'd0);
        step(1'b0, '0, '0, 1'b0, '0, '0, 5'd3, 5'd0, 5'd3);
        idle(5'd3);

        // Destination r0 is discarded and never forwarded.
        step(1'b0, '0, '0, 1'b1, 5'd0, 32'hdead, 5'd0, 5'd0, 5'd0);
        step(1'b0, '0, '0, 1'b0, '0, '0, 5'd0, 5'd0, 5'd0);
        step(1'b1, 5'd0, 32'hbeef, 1'b1, 5'd7, 32'h77, 5'd7, 5'd0, 5'd7);
        idle(5'd7);
        idle(5'd7);

        // Fill with pairs until not ready, then one extra push that must be dropped.
        for (int i = 0; i < 10 && q.size() <= DEPTH - 2; i++) begin
            step(1'b1, AW'(4 + i), DW'(32'h100 + i), 1'b1, AW'(4 + i), DW'(32'h200 + i),
                 AW'(4 + i), AW'(3 + i), 5'd4);
        end
        step(1'b1, 5'd9, 32'hbad0bad0, 1'b0, '0, '0, 5'd9, 5'd4, 5'd5);
        for (int i = 0; i < 10 && q.size() > 0; i++) idle(5'd5);
        idle(5'd9);

        // Single ALU writes r1..r10, one per cycle: steady one-deep, pointers wrap.
        do_reset(5'd0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, '0, '0, 1'b1, AW'(i), DW'(i * 32'h101), AW'(i - 1), AW'(i), 5'd1);
        end
        idle(5'd10);

        // Simultaneous enqueue and drain at count 2.
        step(1'b1, 5'd12, 32'hc1, 1'b1, 5'd13, 32'hc2, 5'd12, 5'd13, 5'd0);
        step(1'b1, 5'd14, 32'hc3, 1'b1, 5'd12, 32'hc4, 5'd12, 5'd13, 5'd14);
        idle(5'd12);

        // Reset mid-traffic with entries pending.
        step(1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h67, 5'd6, 5'd0, 5'd0);
        do_reset(5'd6);
        idle(5'd6);

        // Randomised traffic over a narrow register range to provoke matches.
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc % 150 == 149) begin
                do_reset(AW'($urandom_range(0, 7)));
            end else begin
                step(($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)), DW'($urandom),
                     ($urandom_range(0, 2) != 0), AW'($urandom_range(0, 7)), DW'($urandom),
                     AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            end
        end
        for (int i = 0; i < 8; i++) idle(AW'($urandom_range(0, 7)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
